redmule_w_gidx_tracker: RTL and testbench

- Upstream companion of the W buffer in dequantization mode.
- Maps each incoming global quantization-group index (one per W row, delivered by the W streamer) onto one of H scale/zero slots of the W buffer.
- Reports whether the group's scales are already resident, which suppresses the rewrite.
- Drives the W buffer's next_gidx_i / new_gidx_i pair and keeps slots referenced by the current H-row window from being evicted.

---
 rtl/redmule_w_gidx_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_redmule_w_gidx_tracker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_w_gidx_tracker.sv
// -----------------------------------------------------------------------------
// redmule_w_gidx_tracker
//
// Maps each global quantization-group index delivered by the W streamer onto
// one of H scale/zero slots of the W buffer. A resident group is reported as a
// hit so the W buffer skips rewriting its scales. Slots referenced by the
// current H-row window are pinned and never chosen as eviction victims.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear (same strobe as the W buffer clear)
//   dequant_i       dequantization mode enable, static during a job
//   gidx_valid_i    group index valid from the streamer
//   gidx_i          global group index of the next W row
//   gidx_ready_o    lookup accepted when valid and ready are both high
//   load_i          W buffer row-load strobe, consumes the current result
//   slot_valid_o    slot_o/hit_o hold a pending result
//   slot_o          slot for the row (W buffer next_gidx_i)
//   hit_o           group already resident (W buffer new_gidx_i)
//   occupancy_o     number of valid table entries
// -----------------------------------------------------------------------------
module redmule_w_gidx_tracker #(
    parameter int unsigned H      = 4,
    parameter int unsigned GIDX_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  dequant_i,
    input  logic                  gidx_valid_i,
    input  logic [GIDX_W-1:0]     gidx_i,
    output logic                  gidx_ready_o,
    input  logic                  load_i,
    output logic                  slot_valid_o,
    output logic [$clog2(H)-1:0]  slot_o,
    output logic                  hit_o,
    output logic [$clog2(H):0]    occupancy_o
);

    localparam int unsigned SLOT_W = $clog2(H);
    localparam int unsigned OCC_W  = SLOT_W + 1;

    // Tag table and replacement state
    logic [GIDX_W-1:0] tag_q [H];
    logic [H-1:0]      valid_q;
    logic [H-1:0]      pin_q;
    logic [SLOT_W-1:0] ep_q;
    logic [SLOT_W-1:0] wc_q;

    // One-deep result register
    logic              slot_valid_q;
    logic [SLOT_W-1:0] slot_q;
    logic              hit_q;
    logic [OCC_W-1:0]  occ_q;

    // Next-state signals
    logic [GIDX_W-1:0] tag_d [H];
    logic [H-1:0]      valid_d;
    logic [H-1:0]      pin_d;
    logic [SLOT_W-1:0] ep_d;
    logic [SLOT_W-1:0] wc_d;
    logic [OCC_W-1:0]  occ_d;

    logic              accept_c;
    logic              wrap_c;
    logic [H-1:0]      pin_eff_c;
    logic              hit_c;
    logic [SLOT_W-1:0] hit_idx_c;
    logic              victim_found_c;
    logic [SLOT_W-1:0] victim_c;
    logic [SLOT_W-1:0] res_slot_c;
    logic [SLOT_W-1:0] scan_idx;

    assign gidx_ready_o = !clear_i && (!slot_valid_q || load_i);
    assign accept_c     = gidx_valid_i && gidx_ready_o;

    // Loading the last row of a window releases all pins; a lookup accepted in
    // that same cycle already belongs to the next window, so it scans with the
    // released pins and its own pin is applied on top.
    assign wrap_c    = load_i && (wc_q == SLOT_W'(H - 1));
    assign pin_eff_c = wrap_c ? '0 : pin_q;

    // Associative compare against valid entries (tags are unique)
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int unsigned k = 0; k < H; k++) begin
            if (valid_q[k] && (tag_q[k] == gidx_i)) begin
                hit_c     = 1'b1;
                hit_idx_c = SLOT_W'(k);
            end
        end
    end

    // Victim: first unpinned entry scanning from ep; falls back to ep itself
    always_comb begin
        victim_found_c = 1'b0;
        victim_c       = ep_q;
        scan_idx       = '0;
        for (int unsigned i = 0; i < H; i++) begin
            scan_idx = ep_q + SLOT_W'(i);
            if (!victim_found_c && !pin_eff_c[scan_idx]) begin
                victim_found_c = 1'b1;
                victim_c       = scan_idx;
            end
        end
    end

    // Result slot: table slot in dequant mode, otherwise the destination row
    always_comb begin
        if (dequant_i) begin
            res_slot_c = hit_c ? hit_idx_c : victim_c;
        end else begin
            res_slot_c = wc_q + SLOT_W'(slot_valid_q);
        end
    end

    // Table next state
    always_comb begin
        for (int unsigned k = 0; k < H; k++) begin
            tag_d[k] = tag_q[k];
        end
        valid_d = valid_q;
        pin_d   = pin_eff_c;
        ep_d    = ep_q;
        if (accept_c && dequant_i) begin
            if (hit_c) begin
                pin_d[hit_idx_c] = 1'b1;
            end else begin
                tag_d[victim_c]   = gidx_i;
                valid_d[victim_c] = 1'b1;
                pin_d[victim_c]   = 1'b1;
                ep_d              = victim_c + SLOT_W'(1);
            end
        end
    end

    assign wc_d = load_i ? (wc_q + SLOT_W'(1)) : wc_q;

    // Popcount of next valid bits
    always_comb begin
        occ_d = '0;
        for (int unsigned k = 0; k < H; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    // State registers; clear_i overrides every simultaneous event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < H; k++) begin
                tag_q[k] <= '0;
            end
            valid_q      <= '0;
            pin_q        <= '0;
            ep_q         <= '0;
            wc_q         <= '0;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            hit_q        <= 1'b0;
            occ_q        <= '0;
        end else if (clear_i) begin
            valid_q      <= '0;
            pin_q        <= '0;
            ep_q         <= '0;
            wc_q         <= '0;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            hit_q        <= 1'b0;
            occ_q        <= '0;
        end else begin
            for (int unsigned k = 0; k < H; k++) begin
                tag_q[k] <= tag_d[k];
            end
            valid_q <= valid_d;
            pin_q   <= pin_d;
            ep_q    <= ep_d;
            wc_q    <= wc_d;
            occ_q   <= occ_d;
            if (accept_c) begin
                slot_valid_q <= 1'b1;
                slot_q       <= res_slot_c;
                hit_q        <= dequant_i && hit_c;
            end else if (load_i) begin
                slot_valid_q <= 1'b0;
            end
        end
    end

    assign slot_valid_o = slot_valid_q;
    assign slot_o       = slot_q;
    assign hit_o        = hit_q;
    assign occupancy_o  = occ_q;

`ifndef SYNTHESIS
    // More than H pinned groups in one window: the miss overwrites entry ep
    no_victim_on_miss : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(accept_c && dequant_i && !hit_c && !victim_found_c)
    );
`endif

endmodule

// File: tb/tb_redmule_w_gidx_tracker.sv
// -----------------------------------------------------------------------------
// tb_redmule_w_gidx_tracker
//
// Scoreboard bench: the driver advances a behavioural model and queues the
// expected (slot, hit) for each accepted lookup; a monitor pops and compares
// whenever a handshake completes. Directed scenarios are followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_redmule_w_gidx_tracker;

    localparam int unsigned H  = 4;
    localparam int unsigned GW = 16;
    localparam int unsigned SW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          dequant_i;
    logic          gidx_valid_i;
    logic [GW-1:0] gidx_i;
    logic          gidx_ready_o;
    logic          load_i;
    logic          slot_valid_o;
    logic [SW-1:0] slot_o;
    logic          hit_o;
    logic [SW:0]   occupancy_o;

    redmule_w_gidx_tracker #(.H(H), .GIDX_W(GW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .dequant_i    (dequant_i),
        .gidx_valid_i (gidx_valid_i),
        .gidx_i       (gidx_i),
        .gidx_ready_o (gidx_ready_o),
        .load_i       (load_i),
        .slot_valid_o (slot_valid_o),
        .slot_o       (slot_o),
        .hit_o        (hit_o),
        .occupancy_o  (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int slot;
        bit hit;
    } exp_t;
    exp_t sb_q[$];

    int m_tag [H];
    bit m_val [H];
    bit m_pin [H];
    int m_ep;
    int m_wc;
    bit m_pend;
    int m_occ;
    int m_slot;
    bit m_hit;
    bit m_deq;

    task automatic model_reset();
        for (int k = 0; k < H; k++) begin
            m_tag[k] = 0;
            m_val[k] = 0;
            m_pin[k] = 0;
        end
        m_ep = 0; m_wc = 0; m_pend = 0; m_occ = 0; m_slot = 0; m_hit = 0;
    endtask

    task automatic model_step(input bit clr, input bit deq, input bit v, input int g,
                              input bit ld, output bit rdy);
        bit acc;
        bit hit;
        int s;
        rdy = !clr && (!m_pend || ld);
        if (clr) begin
            model_reset();
            return;
        end
        acc = v && rdy;
        // loading the last row of the window releases every pin
        if (ld && m_wc == H - 1)
            for (int k = 0; k < H; k++) m_pin[k] = 0;
        if (acc) begin
            hit = 0;
            s   = -1;
            if (deq) begin
                for (int k = 0; k < H; k++)
                    if (m_val[k] && m_tag[k] == g) begin hit = 1; s = k; end
                if (hit) begin
                    m_pin[s] = 1;
                end else begin
                    for (int i = 0; i < H; i++)
                        if (s < 0 && !m_pin[(m_ep + i) % H]) s = (m_ep + i) % H;
                    if (s < 0) s = m_ep;
                    m_tag[s] = g;
                    m_val[s] = 1;
                    m_pin[s] = 1;
                    m_ep     = (s + 1) % H;
                end
            end else begin
                s = (m_wc + int'(m_pend)) % H;
            end
            m_occ = 0;
            for (int k = 0; k < H; k++) m_occ += int'(m_val[k]);
            sb_q.push_back('{slot: s, hit: hit});
            m_slot = s;
            m_hit  = hit;
        end
        if (ld) m_wc = (m_wc + 1) % H;
        if (acc) m_pend = 1;
        else if (ld) m_pend = 0;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit clr, input bit v, input int g, input bit ld);
        bit rdy;
        @(negedge clk_i);
        chk("slot_valid", int'(slot_valid_o), int'(m_pend));
        chk("occupancy", int'(occupancy_o), m_occ);
        if (m_pend) begin
            chk("slot_hold", int'(slot_o), m_slot);
            chk("hit_hold", int'(hit_o), int'(m_hit));
        end
        clear_i      = clr;
        dequant_i    = m_deq;
        gidx_valid_i = v;
        gidx_i       = GW'(g);
        load_i       = ld;
        #1;
        model_step(clr, m_deq, v, g, ld, rdy);
        chk("gidx_ready", int'(gidx_ready_o), int'(rdy));
    endtask

    // lookup with the pending result consumed in the same cycle
    task automatic issue(input int g);
        cycle(0, 1, g, m_pend);
    endtask

    task automatic do_clear(input bit deq);
        m_deq = deq;
        cycle(1, 1, 99, m_pend);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit   fire;
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            fire = rst_ni && gidx_valid_i && gidx_ready_o;
            @(posedge clk_i);
            #1;
            if (fire) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_slot", int'(slot_o), e.slot);
                    chk("sb_hit", int'(hit_o), int'(e.hit));
                    chk("sb_valid", int'(slot_valid_o), 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; dequant_i = 1'b1; gidx_valid_i = 1'b0;
        gidx_i = '0; load_i = 1'b0;
        m_deq = 1;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_slot_valid", int'(slot_valid_o), 0);
        chk("rst_slot", int'(slot_o), 0);
        chk("rst_hit", int'(hit_o), 0);
        chk("rst_occupancy", int'(occupancy_o), 0);
        rst_ni = 1'b1;
        #1;
        chk("rst_ready", int'(gidx_ready_o), 1);

        // resident group reuse
        do_clear(1);
        issue(5); issue(5); issue(7); issue(5);
        cycle(0, 0, 0, 1);
        chk("reuse_occupancy", int'(occupancy_o), 2);

        // window wrap evicts the oldest unpinned tag
        do_clear(1);
        issue(1); issue(2); issue(3); issue(4); issue(9); issue(2);
        cycle(0, 0, 0, 1);
        chk("wrap_occupancy", int'(occupancy_o), 4);

        // backpressure: one accept, then stalled
        do_clear(1);
        issue(11);
        repeat (5) cycle(0, 1, 12, 0);
        chk("bp_slot_stable", int'(slot_o), 0);
        cycle(0, 1, 12, 1);
        cycle(0, 0, 0, 1);

        // pinned slots are skipped by the eviction scan
        do_clear(1);
        issue(1); issue(2); issue(3); issue(4);
        issue(1); issue(2); issue(8);
        cycle(0, 0, 0, 1);
        chk("pin_skip_slot", int'(slot_o), 2);
        chk("pin_skip_hit", int'(hit_o), 0);

        // clear with a pending result and a simultaneous lookup
        do_clear(1);
        issue(6);
        cycle(1, 1, 7, 0);
        issue(3);
        chk("clr_slot_valid", int'(slot_valid_o), 0);
        chk("clr_occupancy", int'(occupancy_o), 0);
        cycle(0, 0, 0, 1);
        chk("clr_refill_slot", int'(slot_o), 0);
        chk("clr_refill_hit", int'(hit_o), 0);

        // pass-through mode: row index, never a hit
        do_clear(0);
        repeat (6) issue($urandom_range(0, 9));
        cycle(0, 0, 0, 1);
        chk("nodeq_slot", int'(slot_o), 1);
        chk("nodeq_occupancy", int'(occupancy_o), 0);

        // randomized phase
        do_clear(1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_clear(($urandom_range(0, 3) != 0));
            end else begin
                cycle(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 9),
                      m_pend && ($urandom_range(0, 3) != 0));
            end
        end

        // drain with a bounded budget
        for (int n = 0; n < 10 && (m_pend || sb_q.size() != 0); n++)
            cycle(0, 0, 0, m_pend);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
